// File: rtl/minesweeper_pkg.sv
// rtl/minesweeper_pkg.sv - shared board constants, FSM encoding and LFSR helpers
package minesweeper_pkg;

    localparam int         BOARD_CELLS = 25;
    localparam int         MAX_MINES   = 24;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } placer_state_t;

    // One right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic [7:0] shifted;
        shifted = {1'b0, s[7:1]};
        return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    function automatic logic [4:0] clamp_target(input logic [4:0] n);
        if (n == 5'd0) begin
            return 5'd1;
        end else if (n > 5'(MAX_MINES)) begin
            return 5'(MAX_MINES);
        end
        return n;
    endfunction

endpackage

// File: rtl/mine_lfsr.sv
// rtl/mine_lfsr.sv - free-running 8-bit Galois LFSR with optional double step
module mine_lfsr
    import minesweeper_pkg::*;
(
    input  logic       in_clka,
    input  logic       in_restart,
    input  logic       in_double,
    output logic [7:0] out_state
);

    logic [7:0] r_lfsr;
    logic [7:0] w_step1;
    logic [7:0] w_next;

    assign w_step1   = lfsr_step(r_lfsr);
    assign w_next    = in_double ? lfsr_step(w_step1) : w_step1;
    assign out_state = r_lfsr;

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_next;
        end
    end

endmodule

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - random 5x5 mine map generator; MINE_PLACER_SAFE_CELL_EN adds a protected cell
module mine_placer
    import minesweeper_pkg::*;
(
    input  logic        in_clka,
    input  logic        in_restart,
    input  logic        in_place,
    input  logic [4:0]  in_mines_num,
    input  logic        in_mult,
    input  logic        in_increment,
`ifdef MINE_PLACER_SAFE_CELL_EN
    input  logic [4:0]  in_safe_cell,
`endif
    output logic [24:0] out_mines,
    output logic        out_place_done,
    output logic        out_busy,
    output logic [4:0]  out_placed_cnt,
    output logic [1:0]  out_state
);

    placer_state_t r_state;
    placer_state_t w_next_state;
    logic [24:0]   r_mines;
    logic [4:0]    r_cnt;
    logic [4:0]    r_target;
    logic [7:0]    w_lfsr;
    logic [7:0]    w_sum;
    logic [4:0]    w_cand;
    logic [31:0]   w_mines_ext;
    logic [4:0]    w_cnt_next;
    logic          w_excluded;
    logic          w_accept;

    mine_lfsr u_lfsr (
        .in_clka    (in_clka),
        .in_restart (in_restart),
        .in_double  (in_mult),
        .out_state  (w_lfsr)
    );

    // Candidate wraps modulo 32, so 31+1 lands on cell 0.
    assign w_sum       = w_lfsr + {7'd0, in_increment};
    assign w_cand      = 5'(w_sum % 8'd32);
    assign w_mines_ext = {7'd0, r_mines};
    assign w_cnt_next  = r_cnt + 5'd1;

`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [4:0] r_safe;

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            r_safe <= 5'd31;
        end else if (r_state == ST_IDLE && in_place) begin
            r_safe <= in_safe_cell;
        end
    end

    assign w_excluded = (w_cand == r_safe);
`else
    assign w_excluded = 1'b0;
`endif

    assign w_accept = (r_state == ST_GEN) && (w_cand < 5'(BOARD_CELLS))
                      && !w_mines_ext[w_cand] && !w_excluded;

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_place) w_next_state = ST_GEN;
            ST_GEN:  if (w_accept && w_cnt_next == r_target) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            r_mines  <= 25'd0;
            r_cnt    <= 5'd0;
            r_target <= 5'd1;
        end else if (r_state == ST_IDLE && in_place) begin
            r_mines  <= 25'd0;
            r_cnt    <= 5'd0;
            r_target <= clamp_target(in_mines_num);
        end else if (w_accept) begin
            r_mines  <= r_mines | (25'd1 << w_cand);
            r_cnt    <= w_cnt_next;
        end
    end

    assign out_mines      = r_mines;
    assign out_placed_cnt = r_cnt;
    assign out_busy       = (r_state == ST_GEN);
    assign out_place_done = (r_state == ST_DONE);
    assign out_state      = r_state;

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - randomized checks of mine_placer against a behavioural board model
module tb_mine_placer;

    logic        in_clka = 1'b0;
    logic        in_restart;
    logic        in_place;
    logic [4:0]  in_mines_num;
    logic        in_mult;
    logic        in_increment;
`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [4:0]  in_safe_cell;
`endif
    logic [24:0] out_mines;
    logic        out_place_done;
    logic        out_busy;
    logic [4:0]  out_placed_cnt;
    logic [1:0]  out_state;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    int m_mode;
    int m_lfsr;
    int m_cnt;
    int m_target;
    int m_safe;
    bit m_map[25];

    always #5 in_clka = ~in_clka;

    mine_placer dut (
        .in_clka        (in_clka),
        .in_restart     (in_restart),
        .in_place       (in_place),
        .in_mines_num   (in_mines_num),
        .in_mult        (in_mult),
        .in_increment   (in_increment),
`ifdef MINE_PLACER_SAFE_CELL_EN
        .in_safe_cell   (in_safe_cell),
`endif
        .out_mines      (out_mines),
        .out_place_done (out_place_done),
        .out_busy       (out_busy),
        .out_placed_cnt (out_placed_cnt),
        .out_state      (out_state)
    );

    function automatic int lfsr_next(input int s);
        return (s & 1) ? ((s >> 1) ^ 'hB8) : (s >> 1);
    endfunction

    function automatic int clamp(input int n);
        if (n < 1) return 1;
        if (n > 24) return 24;
        return n;
    endfunction

    function automatic int cur_safe();
`ifdef MINE_PLACER_SAFE_CELL_EN
        return int'(in_safe_cell);
`else
        return 31;
`endif
    endfunction

    function automatic logic [24:0] model_vec();
        logic [24:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[i] = m_map[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_lfsr = 'hA5;
        m_cnt  = 0;
        m_safe = 31;
        for (int i = 0; i < 25; i++) m_map[i] = 1'b0;
    endtask

    // Board-level rules applied once per rising edge using the inputs present before it.
    task automatic model_edge();
        int c;
        case (m_mode)
            0: if (in_place) begin
                for (int i = 0; i < 25; i++) m_map[i] = 1'b0;
                m_cnt    = 0;
                m_target = clamp(int'(in_mines_num));
                m_safe   = cur_safe();
                m_mode   = 1;
            end
            1: begin
                c = ((m_lfsr & 31) + int'(in_increment)) % 32;
                if (c < 25 && !m_map[c] && c != m_safe) begin
                    m_map[c] = 1'b1;
                    m_cnt++;
                    if (m_cnt == m_target) m_mode = 2;
                end
            end
            default: m_mode = 0;
        endcase
        m_lfsr = lfsr_next(m_lfsr);
        if (in_mult) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic compare_all();
        check("state", 32'(out_state), 32'(m_mode));
        check("busy", 32'(out_busy), 32'(m_mode == 1));
        check("done", 32'(out_place_done), 32'(m_mode == 2));
        check("placed_cnt", 32'(out_placed_cnt), 32'(m_cnt));
        check("mines", 32'(out_mines), 32'(model_vec()));
        check("popcount", 32'($countones(out_mines)), 32'(out_placed_cnt));
    endtask

    task automatic step(input bit rand_ctrl);
        if (rand_ctrl) begin
            in_mult      = 1'($urandom_range(0, 1));
            in_increment = 1'($urandom_range(0, 1));
        end
        model_edge();
        @(posedge in_clka);
        #1;
        compare_all();
        if (out_place_done) n_done++;
    endtask

    task automatic do_reset();
        in_restart = 1'b1;
        in_place   = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge in_clka);
        #1;
        in_restart = 1'b0;
    endtask

    task automatic place(input int num, input bit mult, input bit inc, input bit hold,
                         input bit rand_ctrl, input int budget, output int lat);
        in_mines_num = 5'(num);
        in_mult      = mult;
        in_increment = inc;
        in_place     = 1'b1;
        n_done       = 0;
        step(1'b0);
        if (!hold) in_place = 1'b0;
        in_mines_num = 5'($urandom_range(0, 31));
`ifdef MINE_PLACER_SAFE_CELL_EN
        in_safe_cell = 5'($urandom_range(0, 31));
`endif
        lat = 0;
        while (m_mode != 0 && lat < budget) begin
            step(rand_ctrl);
            lat++;
        end
        check("within_budget", 32'(lat < budget), 32'd1);
        check("done_pulses", 32'(n_done), 32'd1);
        check("final_cnt", 32'(out_placed_cnt), 32'(clamp(num)));
        check("final_popcount", 32'($countones(out_mines)), 32'(clamp(num)));
        check("min_latency", 32'(lat >= clamp(num) + 1), 32'd1);
    endtask

    initial begin
        int lat;
        int k;
        logic [24:0] saved;

        in_restart   = 1'b0;
        in_place     = 1'b0;
        in_mines_num = 5'd0;
        in_mult      = 1'b0;
        in_increment = 1'b0;
`ifdef MINE_PLACER_SAFE_CELL_EN
        in_safe_cell = 5'd31;
`endif
        #2;
        do_reset();
        step(1'b0);

        place(3, 0, 0, 0, 0, 800, lat);
        place(0, 0, 0, 0, 0, 800, lat);
        place(31, 0, 0, 0, 0, 6200, lat);

`ifdef MINE_PLACER_SAFE_CELL_EN
        in_safe_cell = 5'd12;
        place(24, 0, 0, 0, 0, 6200, lat);
        check("safe_cell_map", 32'(out_mines), 32'h1FFEFFF);
`endif

        // Restart mid-generation once two of five mines are down.
        in_mines_num = 5'd5;
        in_place     = 1'b1;
        n_done       = 0;
        step(1'b0);
        in_place = 1'b0;
        k = 0;
        while (m_cnt != 2 && k < 2000) begin
            step(1'b0);
            k++;
        end
        check("reached_two", 32'(out_placed_cnt), 32'd2);
        do_reset();
        check("restart_cnt", 32'(out_placed_cnt), 32'd0);
        check("restart_mines", 32'(out_mines), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0);
        check("no_done_after_restart", 32'(n_done), 32'd0);

        // Same stimulus after two resets must give the same map.
        do_reset();
        place(7, 0, 0, 0, 0, 3000, lat);
        saved = out_mines;
        do_reset();
        place(7, 0, 0, 0, 0, 3000, lat);
        check("repeatable_map", 32'(out_mines), 32'(saved));

        place($urandom_range(0, 31), 1, 0, 0, 0, 6200, lat);
        place($urandom_range(0, 31), 0, 1, 0, 0, 6200, lat);
        place($urandom_range(0, 31), 1, 1, 0, 0, 6200, lat);

        // Request held high: one done pulse, then a fresh run starts from IDLE.
        place(4, 0, 0, 1, 0, 3000, lat);
        check("held_still_idle", 32'(out_state), 32'd0);
        step(1'b0);
        check("held_restarts_gen", 32'(out_busy), 32'd1);
        check("held_cleared", 32'(out_placed_cnt), 32'd0);
        in_place = 1'b0;
        k = 0;
        while (m_mode != 0 && k < 3000) begin
            step(1'b0);
            k++;
        end
        check("held_second_finished", 32'(k < 3000), 32'd1);

        for (int r = 0; r < 5; r++) begin
`ifdef MINE_PLACER_SAFE_CELL_EN
            in_safe_cell = 5'($urandom_range(0, 31));
`endif
            place($urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  0, 1'($urandom_range(0, 1)), 8000, lat);
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
